dw_multifunc_issue_ctrl: RTL and testbench

Sequential issue/capture controller that sits directly upstream of a DW_lp_multifunc_DG instance. It accepts one operand and function request per valid/ready handshake and checks the function code. It drives the multifunc inputs from registers and raises DG_ctrl only while an evaluation is in flight. After a fixed multicycle settle window it captures z/status into a registered result that is offered downstream through a second valid/ready handshake.

---
 rtl/dw_multifunc_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_dw_multifunc_issue_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_multifunc_issue_ctrl.sv
// Issue/capture controller in front of a DW_lp_multifunc_DG instance: registers the
// operand/function, gates the datapath for num_cyc settle cycles, then offers z/status.
module dw_multifunc_issue_ctrl #(
   parameter int         op_width    = 24,
   parameter logic [6:0] func_select = 7'h7F,
   parameter int         num_cyc     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [op_width:0]     in_a,
   input  logic [15:0]           in_func,
   output logic [op_width:0]     mf_a,
   output logic [15:0]           mf_func,
   output logic                  mf_DG_ctrl,
   input  logic [op_width+1:0]   mf_z,
   input  logic                  mf_status,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [op_width+1:0]   out_z,
   output logic                  out_status,
   output logic                  out_err,
   output logic                  busy
);

   localparam int CNT_W = (num_cyc > 1) ? $clog2(num_cyc) : 1;

   typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [op_width:0]     mf_a_q, mf_a_d;
   logic [15:0]           mf_func_q, mf_func_d;
   logic                  dg_q, dg_d;
   logic                  vld_q, vld_d;
   logic [op_width+1:0]   z_q, z_d;
   logic                  st_q, st_d;
   logic                  err_q, err_d;

   // A code is legal only if it selects exactly one implemented function.
   function automatic logic func_legal(input logic [15:0] f);
      return (f[15:7] == 9'd0) && $onehot(f[6:0]) && ((f[6:0] & func_select) != 7'd0);
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mf_a_d    = mf_a_q;
      mf_func_d = mf_func_q;
      dg_d      = dg_q;
      z_d       = z_q;
      st_d      = st_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (func_legal(in_func)) begin
                  mf_a_d    = in_a;
                  mf_func_d = in_func;
                  cnt_d     = CNT_W'(num_cyc - 1);
                  dg_d      = 1'b1;
                  state_d   = EVAL;
               end else begin
                  // Rejected codes never reach the multifunc inputs, so it does not toggle.
                  z_d     = '0;
                  st_d    = 1'b0;
                  err_d   = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         EVAL: begin
            if (cnt_q == '0) begin
               z_d     = mf_z;
               st_d    = mf_status;
               err_d   = 1'b0;
               dg_d    = 1'b0;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign vld_d = (state_d == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mf_a_q    <= '0;
         mf_func_q <= '0;
         dg_q      <= 1'b0;
         vld_q     <= 1'b0;
         z_q       <= '0;
         st_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mf_a_q    <= mf_a_d;
         mf_func_q <= mf_func_d;
         dg_q      <= dg_d;
         vld_q     <= vld_d;
         z_q       <= z_d;
         st_q      <= st_d;
         err_q     <= err_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = vld_q;
   assign mf_a       = mf_a_q;
   assign mf_func    = mf_func_q;
   assign mf_DG_ctrl = dg_q;
   assign out_z      = z_q;
   assign out_status = st_q;
   assign out_err    = err_q;

endmodule

// File: tb/tb_dw_multifunc_issue_ctrl.sv
// Bench for dw_multifunc_issue_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model; unit 0 enables all functions, unit 1 only codes 1 and 2.
module tb_dw_multifunc_issue_ctrl;
   localparam int OPW = 24;
   localparam int AW  = OPW + 1;
   localparam int ZW  = OPW + 2;
   localparam int NC  = 3;
   localparam logic [6:0] FS0 = 7'h7F;
   localparam logic [6:0] FS1 = 7'h03;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid [2];
   logic          in_ready [2];
   logic [AW-1:0] in_a     [2];
   logic [15:0]   in_func  [2];
   logic [AW-1:0] mf_a     [2];
   logic [15:0]   mf_func  [2];
   logic          mf_DG_ctrl [2];
   logic [ZW-1:0] mf_z     [2];
   logic          mf_status [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [ZW-1:0] out_z    [2];
   logic          out_status [2];
   logic          out_err  [2];
   logic          busy     [2];

   int tests = 0;
   int fails = 0;

   // Stand-in multifunc result: only valid once the datapath has been enabled long enough.
   function automatic logic [ZW-1:0] fz(input logic [AW-1:0] a, input logic [15:0] f);
      return {a, 1'b0} + ZW'((f == 16'h0002) ? 16'h0 : f);
   endfunction
   function automatic logic fst(input logic [AW-1:0] a, input logic [15:0] f);
      return a[0] ^ f[0];
   endfunction
   function automatic bit legal_m(input logic [15:0] f, input logic [6:0] fs);
      return ($countones(f) == 1) && (f < 16'h0080) && ((f[6:0] & fs) != 7'd0);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      int settle = 0;
      dw_multifunc_issue_ctrl #(.op_width(OPW), .func_select((g == 0) ? FS0 : FS1), .num_cyc(NC)) dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_func(in_func[g]),
         .mf_a(mf_a[g]), .mf_func(mf_func[g]), .mf_DG_ctrl(mf_DG_ctrl[g]),
         .mf_z(mf_z[g]), .mf_status(mf_status[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_z(out_z[g]),
         .out_status(out_status[g]), .out_err(out_err[g]), .busy(busy[g]));
      always_ff @(posedge clk) settle <= mf_DG_ctrl[g] ? settle + 1 : 0;
      assign mf_z[g]      = (mf_DG_ctrl[g] && settle >= NC - 1) ? fz(mf_a[g], mf_func[g]) : '1;
      assign mf_status[g] = (mf_DG_ctrl[g] && settle >= NC - 1) ? fst(mf_a[g], mf_func[g]) : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected multifunc input registers per unit
   logic [AW-1:0] ma  [2];
   logic [15:0]   mfn [2];

   task automatic do_req(input int u, input logic [AW-1:0] a, input logic [15:0] f);
      logic [6:0] fs;
      fs = (u == 0) ? FS0 : FS1;
      in_valid[u] = 1'b1;
      in_a[u]     = a;
      in_func[u]  = f;
      step();
      in_valid[u] = 1'b0;
      if (legal_m(f, fs)) begin
         ma[u]  = a;
         mfn[u] = f;
         for (int k = 0; k < NC; k++) begin
            chk("eval_dg", 64'(mf_DG_ctrl[u]), 64'd1);
            chk("eval_vld", 64'(out_valid[u]), 64'd0);
            chk("eval_rdy", 64'(in_ready[u]), 64'd0);
            step();
         end
         chk("res_z", 64'(out_z[u]), 64'(fz(a, f)));
         chk("res_st", 64'(out_status[u]), 64'(fst(a, f)));
         chk("res_err", 64'(out_err[u]), 64'd0);
      end else begin
         chk("ill_z", 64'(out_z[u]), 64'd0);
         chk("ill_st", 64'(out_status[u]), 64'd0);
         chk("ill_err", 64'(out_err[u]), 64'd1);
      end
      chk("hold_vld", 64'(out_valid[u]), 64'd1);
      chk("hold_dg", 64'(mf_DG_ctrl[u]), 64'd0);
      chk("hold_rdy", 64'(in_ready[u]), 64'd0);
      chk("hold_busy", 64'(busy[u]), 64'd1);
      chk("mf_a", 64'(mf_a[u]), 64'(ma[u]));
      chk("mf_func", 64'(mf_func[u]), 64'(mfn[u]));
   endtask

   task automatic finish_hs(input int u);
      out_ready[u] = 1'b1;
      step();
      out_ready[u] = 1'b0;
      chk("hs_vld", 64'(out_valid[u]), 64'd0);
      chk("hs_rdy", 64'(in_ready[u]), 64'd1);
      chk("hs_busy", 64'(busy[u]), 64'd0);
   endtask

   task automatic chk_reset_vals(input int u);
      chk("rst_vld", 64'(out_valid[u]), 64'd0);
      chk("rst_dg", 64'(mf_DG_ctrl[u]), 64'd0);
      chk("rst_mfa", 64'(mf_a[u]), 64'd0);
      chk("rst_mff", 64'(mf_func[u]), 64'd0);
      chk("rst_z", 64'(out_z[u]), 64'd0);
      chk("rst_st", 64'(out_status[u]), 64'd0);
      chk("rst_err", 64'(out_err[u]), 64'd0);
      chk("rst_busy", 64'(busy[u]), 64'd0);
      chk("rst_rdy", 64'(in_ready[u]), 64'd1);
   endtask

   // Reference model for unit 0: rem = EVAL cycles left, hold = result on offer
   int            m_rem;
   bit            m_hold;
   logic [ZW-1:0] m_z;
   logic          m_st, m_err;
   logic [AW-1:0] rq_a [$];
   logic [15:0]   rq_f [$];

   task automatic run_cycle(input bit rnd, output bit hs);
      bit idle, acc;
      logic [AW-1:0] qa;
      logic [15:0] qf;
      idle = !m_hold && (m_rem == 0);
      if (rnd) begin
         in_valid[0]  = (rq_a.size() > 0) && ($urandom_range(0, 3) != 0);
         out_ready[0] = ($urandom_range(0, 2) != 0);
      end else begin
         in_valid[0]  = (rq_a.size() > 0);
         out_ready[0] = 1'b1;
      end
      if (rq_a.size() > 0) begin
         in_a[0]    = rq_a[0];
         in_func[0] = rq_f[0];
      end
      acc = idle && in_valid[0];
      hs  = m_hold && out_ready[0];
      step();
      if (m_hold) begin
         if (out_ready[0]) m_hold = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_hold = 1;
            m_z    = fz(ma[0], mfn[0]);
            m_st   = fst(ma[0], mfn[0]);
            m_err  = 1'b0;
         end
      end else if (acc) begin
         qa = rq_a.pop_front();
         qf = rq_f.pop_front();
         if (legal_m(qf, FS0)) begin
            ma[0]  = qa;
            mfn[0] = qf;
            m_rem  = NC;
         end else begin
            m_hold = 1;
            m_z    = '0;
            m_st   = 1'b0;
            m_err  = 1'b1;
         end
      end
      chk("m_vld", 64'(out_valid[0]), 64'(m_hold));
      chk("m_rdy", 64'(in_ready[0]), 64'(!m_hold && m_rem == 0));
      chk("m_dg", 64'(mf_DG_ctrl[0]), 64'(m_rem > 0));
      chk("m_busy", 64'(busy[0]), 64'(m_hold || m_rem > 0));
      chk("m_mfa", 64'(mf_a[0]), 64'(ma[0]));
      chk("m_mff", 64'(mf_func[0]), 64'(mfn[0]));
      if (m_hold) begin
         chk("m_z", 64'(out_z[0]), 64'(m_z));
         chk("m_st", 64'(out_status[0]), 64'(m_st));
         chk("m_err", 64'(out_err[0]), 64'(m_err));
      end
   endtask

   initial begin
      int hs_cnt;
      int hs_t [$];
      bit hs;
      logic [15:0] rf;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0; in_a[u] = '0; in_func[u] = '0; out_ready[u] = 1'b0;
         ma[u] = '0; mfn[u] = '0;
      end

      // Reset: values appear asynchronously, requests during reset are ignored
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals(0);
      chk_reset_vals(1);
      in_valid[0] = 1'b1; in_a[0] = 25'h0000123; in_func[0] = 16'h0001;
      step();
      chk("rst_noacc_busy", 64'(busy[0]), 64'd0);
      chk("rst_noacc_dg", 64'(mf_DG_ctrl[0]), 64'd0);
      in_valid[0] = 1'b0;
      #2 rst_n = 1'b1;
      step();

      // Legal square-root request
      do_req(0, 25'h0800000, 16'h0002);
      chk("sqrt_z", 64'(out_z[0]), 64'h1000000);
      finish_hs(0);

      // Illegal codes: multi-hot and out-of-range
      do_req(0, 25'h1ABCDEF, 16'h0003);
      finish_hs(0);
      do_req(0, 25'h0055AA5, 16'h0080);
      finish_hs(0);

      // Masked function on unit 1, then an enabled one
      do_req(1, 25'h0000444, 16'h0004);
      finish_hs(1);
      do_req(1, 25'h0123457, 16'h0001);
      finish_hs(1);

      // Backpressure with a pending request
      do_req(0, 25'h0ABCDE1, 16'h0010);
      in_valid[0] = 1'b1; in_a[0] = 25'h1111111; in_func[0] = 16'h0040;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_vld", 64'(out_valid[0]), 64'd1);
         chk("bp_rdy", 64'(in_ready[0]), 64'd0);
         chk("bp_dg", 64'(mf_DG_ctrl[0]), 64'd0);
         chk("bp_z", 64'(out_z[0]), 64'(fz(25'h0ABCDE1, 16'h0010)));
         chk("bp_st", 64'(out_status[0]), 64'(fst(25'h0ABCDE1, 16'h0010)));
         chk("bp_mfa", 64'(mf_a[0]), 64'(ma[0]));
      end
      out_ready[0] = 1'b1;
      step();
      out_ready[0] = 1'b0;
      chk("bp_idle_vld", 64'(out_valid[0]), 64'd0);
      chk("bp_idle_rdy", 64'(in_ready[0]), 64'd1);
      do_req(0, 25'h1111111, 16'h0040);
      finish_hs(0);

      // Reset during the second EVAL cycle
      in_valid[0] = 1'b1; in_a[0] = 25'h0F0F0F0; in_func[0] = 16'h0008;
      step();
      in_valid[0] = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals(0);
      ma[0] = '0; mfn[0] = '0;
      ma[1] = '0; mfn[1] = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("post_rst_vld", 64'(out_valid[0]), 64'd0);
         chk("post_rst_dg", 64'(mf_DG_ctrl[0]), 64'd0);
      end
      do_req(0, 25'h0000321, 16'h0020);
      finish_hs(0);

      // Model-checked phases start from a clean reset
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      ma[0] = '0; mfn[0] = '0;
      m_rem = 0; m_hold = 0; m_z = '0; m_st = 1'b0; m_err = 1'b0;
      step();

      // Back-to-back legal requests; each takes idle + NC eval + hold cycles
      for (int k = 0; k < 4; k++) begin
         rq_a.push_back(AW'($urandom));
         rq_f.push_back(16'(1 << $urandom_range(0, 6)));
      end
      hs_cnt = 0;
      for (int c = 0; c < 24; c++) begin
         run_cycle(1'b0, hs);
         if (hs) begin
            hs_cnt++;
            hs_t.push_back(c);
         end
      end
      chk("b2b_count", 64'(hs_cnt), 64'd4);
      for (int k = 1; k < hs_t.size(); k++)
         chk("b2b_space", 64'(hs_t[k] - hs_t[k-1]), 64'(NC + 2));

      // Randomized traffic with mixed legal/illegal codes and backpressure
      for (int c = 0; c < 400; c++) begin
         if (rq_a.size() == 0) begin
            if ($urandom_range(0, 1) == 0) rf = 16'(1 << $urandom_range(0, 6));
            else rf = 16'($urandom);
            rq_a.push_back(AW'($urandom));
            rq_f.push_back(rf);
         end
         run_cycle(1'b1, hs);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
